// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one 1024x20 single-port RAM between a fetch port
// (read-only) and a data port (read/write); one access every three cycles.
module ram_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [9:0]  if_addr,
   output logic        if_ready,
   output logic [19:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [9:0]  dm_addr,
   input  logic [19:0] dm_wdata,
   output logic        dm_ready,
   output logic [19:0] dm_rdata,
   output logic [9:0]  ram_addr,
   output logic [19:0] ram_write,
   output logic        ram_str,
   output logic        ram_ld,
   input  logic [19:0] ram_read
);

   typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

   state_t state;
   logic   win_dm;
   logic   last_dm;
   logic   pick_dm;

   // Data port wins when alone, under fixed priority, or when fetch won last time.
   always_comb begin
      pick_dm = dm_req && (!if_req || !FAIR || !last_dm);
   end

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values, whatever order the statements appear in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         win_dm    <= 1'b0;
         last_dm   <= 1'b0;
         ram_addr  <= '0;
         ram_write <= '0;
         ram_str   <= 1'b0;
         ram_ld    <= 1'b0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               if (if_req || dm_req) begin
                  win_dm    <= pick_dm;
                  ram_addr  <= pick_dm ? dm_addr : if_addr;
                  ram_write <= dm_wdata;
                  // The strobe/load pair doubles as the latched dm_we.
                  ram_str   <= pick_dm && dm_we;
                  ram_ld    <= !(pick_dm && dm_we);
                  state     <= SERVE;
               end
            end
            SERVE: begin
               ram_str <= 1'b0;
               ram_ld  <= 1'b0;
               if (ram_ld) begin
                  if (win_dm) dm_rdata <= ram_read;
                  else        if_rdata <= ram_read;
               end
               state <= RESP;
            end
            RESP: begin
               if_ready <= !win_dm;
               dm_ready <= win_dm;
               last_dm  <= win_dm;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: reset values, a vector table of single accesses,
// round-robin and fixed-priority contention, reset mid-access, random traffic.
module tb_ram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        if_req, if_ready, dm_req, dm_we, dm_ready, ram_str, ram_ld;
   logic [9:0]  if_addr, dm_addr, ram_addr;
   logic [19:0] if_rdata, dm_wdata, dm_rdata, ram_write, ram_read;

   logic        fp_if_req, fp_if_ready, fp_dm_req, fp_dm_we, fp_dm_ready, fp_ram_str, fp_ram_ld;
   logic [9:0]  fp_if_addr, fp_dm_addr, fp_ram_addr;
   logic [19:0] fp_if_rdata, fp_dm_wdata, fp_dm_rdata, fp_ram_write, fp_ram_read;

   ram_arbiter #(.FAIR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .ram_addr(ram_addr), .ram_write(ram_write), .ram_str(ram_str), .ram_ld(ram_ld),
      .ram_read(ram_read)
   );

   ram_arbiter #(.FAIR(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .if_req(fp_if_req), .if_addr(fp_if_addr), .if_ready(fp_if_ready), .if_rdata(fp_if_rdata),
      .dm_req(fp_dm_req), .dm_we(fp_dm_we), .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata),
      .dm_ready(fp_dm_ready), .dm_rdata(fp_dm_rdata),
      .ram_addr(fp_ram_addr), .ram_write(fp_ram_write), .ram_str(fp_ram_str), .ram_ld(fp_ram_ld),
      .ram_read(fp_ram_read)
   );

   // Shared RAM: synchronous write, combinational read gated by ram_ld.
   logic [19:0] mem [1024];
   always @(posedge clk) if (ram_str) mem[ram_addr] <= ram_write;
   assign ram_read    = ram_ld ? mem[ram_addr] : 20'hDEAD0;
   assign fp_ram_read = fp_ram_ld ? 20'h11111 : 20'h0;

   int          total = 0;
   int          bad = 0;
   int          viol = 0;
   bit          mon_en = 1'b0;
   logic [19:0] shadow [1024];
   logic [19:0] dm_last;

   typedef struct {
      bit          dm;
      bit          we;
      logic [9:0]  addr;
      logic [19:0] wdata;
      logic [19:0] exp_rdata;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] pick_addr();
      int r;
      r = $urandom_range(0, 8);
      return (r == 8) ? 10'h3FF : 10'(r);
   endfunction

   // One uncontended access, started at a falling edge; returns that port's rdata.
   task automatic do_access(input bit dm, input bit we, input logic [9:0] addr,
                            input logic [19:0] wdata, output logic [19:0] rd);
      int          lat, str_n, ld_n;
      logic [9:0]  seen_addr;
      logic [19:0] seen_wdata;
      logic        got;
      lat = 0; str_n = 0; ld_n = 0; seen_addr = '0; seen_wdata = '0; got = 1'b0;
      if (dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         if (ram_str) begin str_n++; seen_wdata = ram_write; end
         if (ram_ld) ld_n++;
         if (ram_str || ram_ld) seen_addr = ram_addr;
         got = dm ? dm_ready : if_ready;
      end
      dm_req = 1'b0; if_req = 1'b0;
      rd = dm ? dm_rdata : if_rdata;
      check("acc_latency", 32'(lat), 32'd3);
      check("acc_str_cycles", 32'(str_n), (dm && we) ? 32'd1 : 32'd0);
      check("acc_ld_cycles", 32'(ld_n), (dm && we) ? 32'd0 : 32'd1);
      check("acc_ram_addr", 32'(seen_addr), 32'(addr));
      if (dm && we) begin
         check("acc_ram_write", 32'(seen_wdata), 32'(wdata));
         shadow[addr] = wdata;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (if_ready && dm_ready) viol++;
         if (ram_str && ram_ld) viol++;
         if (ram_str && !(dm_req && dm_we && ram_addr == dm_addr && ram_write == dm_wdata)) viol++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [19:0] rd;
      int          pulses, both, fp_dm_n, fp_if_n, n, rdy_seen;
      logic        got;

      vecs[0] = '{1'b1, 1'b1, 10'h005, 20'hABCDE, 20'h00000};
      vecs[1] = '{1'b0, 1'b0, 10'h005, 20'h00000, 20'hABCDE};
      vecs[2] = '{1'b1, 1'b1, 10'h000, 20'h00001, 20'h00000};
      vecs[3] = '{1'b1, 1'b1, 10'h003, 20'h33333, 20'h00000};
      vecs[4] = '{1'b1, 1'b1, 10'h3FF, 20'hFFFFF, 20'h00000};
      vecs[5] = '{1'b1, 1'b0, 10'h3FF, 20'h00000, 20'hFFFFF};
      vecs[6] = '{1'b1, 1'b1, 10'h3FF, 20'h12345, 20'hFFFFF};
      vecs[7] = '{1'b1, 1'b0, 10'h005, 20'h00000, 20'hABCDE};
      vecs[8] = '{1'b0, 1'b0, 10'h000, 20'h00000, 20'h00001};
      vecs[9] = '{1'b0, 1'b0, 10'h3FF, 20'h00000, 20'h12345};

      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      fp_if_req = 0; fp_if_addr = 0; fp_dm_req = 0; fp_dm_we = 0; fp_dm_addr = 0; fp_dm_wdata = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ram_str", 32'(ram_str), 32'd0);
      check("rst_ram_ld", 32'(ram_ld), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_dm_ready", 32'(dm_ready), 32'd0);
      check("rst_if_rdata", 32'(if_rdata), 32'd0);
      check("rst_dm_rdata", 32'(dm_rdata), 32'd0);
      check("rst_fp_outputs", 32'({fp_ram_str, fp_ram_ld, fp_ram_addr, fp_ram_write}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Both ports requesting continuously on both instances.
      if_req = 1; dm_req = 1; dm_we = 0; if_addr = 10'd1; dm_addr = 10'd2;
      fp_if_req = 1; fp_dm_req = 1; fp_dm_we = 0; fp_if_addr = 10'd1; fp_dm_addr = 10'd2;
      pulses = 0; both = 0; fp_dm_n = 0; fp_if_n = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (if_ready && dm_ready) both++;
         if (if_ready || dm_ready) begin
            check($sformatf("rr_pulse%0d_cycle", pulses), 32'(c), 32'(3 * (pulses + 1)));
            check($sformatf("rr_pulse%0d_is_dm", pulses), 32'(dm_ready), 32'(pulses % 2 == 0));
            pulses++;
         end
         fp_dm_n += int'(fp_dm_ready);
         fp_if_n += int'(fp_if_ready);
      end
      check("rr_pulse_count", 32'(pulses), 32'd5);
      check("rr_simultaneous_ready", 32'(both), 32'd0);
      check("fp_dm_grants", 32'(fp_dm_n), 32'd5);
      check("fp_if_starved", 32'(fp_if_n), 32'd0);
      fp_dm_req = 0;
      n = 0; got = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         got = fp_if_ready;
      end
      check("fp_if_after_dm_drop", 32'(got), 32'd1);

      rst_n = 1'b0;
      if_req = 0; dm_req = 0; fp_if_req = 0; fp_dm_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_access(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
         check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      end
      @(negedge clk);
      check("hold_ram_addr", 32'(ram_addr), 32'h3FF);
      check("hold_ram_str_idle", 32'({ram_str, ram_ld}), 32'd0);
      check("hold_dm_rdata", 32'(dm_rdata), 32'hABCDE);
      check("hold_if_rdata", 32'(if_rdata), 32'h12345);

      // Reset during the SERVE cycle of a write to address 3.
      dm_req = 1; dm_we = 1; dm_addr = 10'h003; dm_wdata = 20'h77777;
      @(negedge clk);
      check("mid_str_before_reset", 32'(ram_str), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_ram_str", 32'(ram_str), 32'd0);
      check("mid_ram_ld", 32'(ram_ld), 32'd0);
      check("mid_ram_addr", 32'(ram_addr), 32'd0);
      check("mid_ram_write", 32'(ram_write), 32'd0);
      check("mid_rdata", 32'({if_rdata, dm_rdata[11:0]}), 32'd0);
      check("mid_dm_rdata_hi", 32'(dm_rdata[19:12]), 32'd0);
      dm_req = 0;
      rdy_seen = 0;
      repeat (4) begin
         @(negedge clk);
         rdy_seen += int'(dm_ready) + int'(if_ready);
      end
      check("mid_no_ready", 32'(rdy_seen), 32'd0);
      rst_n = 1'b1;
      do_access(1'b1, 1'b0, 10'h003, 20'h0, rd);
      check("mid_write_abandoned", 32'(rd), 32'h33333);

      for (int a = 0; a < 8; a++) do_access(1'b1, 1'b1, 10'(a), 20'($urandom), rd);
      do_access(1'b1, 1'b1, 10'h3FF, 20'($urandom), rd);
      dm_last = 20'h33333;

      mon_en = 1'b1;
      fork
         begin
            int          gap, w;
            logic [9:0]  a;
            for (int t = 0; t < 40; t++) begin
               gap = $urandom_range(0, 3);
               repeat (gap) @(negedge clk);
               a = pick_addr();
               if_addr = a; if_req = 1;
               w = 0;
               do begin @(negedge clk); w++; end while (!if_ready && w < 20);
               if_req = 0;
               check("rnd_if_wait_le6", 32'(w <= 6), 32'd1);
               check("rnd_if_rdata", 32'(if_rdata), 32'(shadow[a]));
            end
         end
         begin
            int          gap, w;
            logic [9:0]  a;
            logic        we;
            logic [19:0] wd;
            for (int t = 0; t < 40; t++) begin
               gap = $urandom_range(0, 3);
               repeat (gap) @(negedge clk);
               a = pick_addr(); we = 1'($urandom); wd = 20'($urandom);
               dm_addr = a; dm_we = we; dm_wdata = wd; dm_req = 1;
               w = 0;
               do begin @(negedge clk); w++; end while (!dm_ready && w < 20);
               dm_req = 0;
               check("rnd_dm_wait_le6", 32'(w <= 6), 32'd1);
               if (we) begin
                  check("rnd_dm_rdata_kept", 32'(dm_rdata), 32'(dm_last));
                  shadow[a] = wd;
               end else begin
                  check("rnd_dm_rdata", 32'(dm_rdata), 32'(shadow[a]));
                  dm_last = shadow[a];
               end
            end
         end
      join
      mon_en = 1'b0;
      check("rnd_protocol_violations", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin between ports; 0 = data port has fixed priority.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  fetch-port access request.
REQ-005 SHALL have port if_addr  input  10  fetch-port word address.
REQ-006 SHALL have port if_ready  output  1  fetch-port one-cycle completion pulse.
REQ-007 SHALL have port if_rdata  output  20  fetch-port registered read data.
REQ-008 SHALL have port dm_req  input  1  data-port access request.
REQ-009 SHALL have port dm_we  input  1  data-port write (1) or read (0).
REQ-010 SHALL have port dm_addr  input  10  data-port word address.
REQ-011 SHALL have port dm_wdata  input  20  data-port write data.
REQ-012 SHALL have port dm_ready  output  1  data-port one-cycle completion pulse.
REQ-013 SHALL have port dm_rdata  output  20  data-port registered read data.
REQ-014 SHALL have port ram_addr  output  10  address to the shared 1024x20 RAM.
REQ-015 SHALL have port ram_write  output  20  write data to the RAM.
REQ-016 SHALL have port ram_str  output  1  RAM write strobe; the RAM writes on the clk edge while high.
REQ-017 SHALL have port ram_ld  output  1  RAM load enable; the RAM read is combinational while high.
REQ-018 SHALL have port ram_read  input  20  RAM read data; valid only while ram_ld is high.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, SERVE, RESP.
REQ-020 IDLE: when no request is asserted, SHALL remain in IDLE.
REQ-021 IDLE: when any request is asserted, SHALL latch the winner, its address, dm_we and dm_wdata, then go to SERVE.
REQ-022 Winner, single request: that requester.
REQ-023 Winner, both requesting, FAIR=1: the port that was not last_winner.
REQ-024 Winner, both requesting, FAIR=0: always the data port.
REQ-025 SERVE: SHALL drive ram_addr and ram_write from the latched values.
REQ-026 SERVE: SHALL assert ram_str for a data-port write, or ram_ld for any read; never both.
REQ-027 SERVE: on a read, SHALL capture ram_read into the winner's rdata register at the end of the cycle, then go to RESP.
REQ-028 RESP: SHALL assert the winner's ready for exactly one cycle, set last_winner to the winner, then go to IDLE.
REQ-029 Latency: a request sampled in IDLE at edge N SHALL yield ready high during the cycle after edge N+2; throughput is one access per 3 cycles.
REQ-030 Requesters hold req, addr, we and wdata stable until their ready is seen; a request still high in the cycle after ready is treated as a new request.
REQ-031 The fetch port SHALL never cause ram_str; there is no fetch write path.
REQ-032 ram_str and ram_ld SHALL be 0 in IDLE and RESP.
REQ-033 ram_addr and ram_write SHALL hold the last latched values outside SERVE.
REQ-034 if_rdata and dm_rdata SHALL hold their last read values until that port's next read completes; a data-port write SHALL leave dm_rdata unchanged.
REQ-035 At most one ready output SHALL be high in any cycle.
REQ-036 The losing request SHALL remain pending and be granted at the next IDLE without being dropped.
REQ-037 Addresses SHALL pass through unmodified; there is no wrap or bounds logic, and 1023 is a legal address.

Reset
REQ-038 rst_n low SHALL immediately force, independent of clk: state=IDLE, last_winner=fetch port, ram_str=0, ram_ld=0, ram_addr=0, ram_write=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
REQ-039 An access in flight when reset asserts SHALL be abandoned with no ready pulse; the requester re-issues it after release.
REQ-040 After rst_n rises, the first arbitration SHALL occur at the first rising clk edge with rst_n high.

Verification
REQ-041 Data write: dm_req=1, dm_we=1, dm_addr=10'h005, dm_wdata=20'hABCDE -> ram_str high for one cycle with ram_addr=5; dm_ready pulses 2 cycles after the grant edge.
REQ-042 Fetch read: if_req=1, if_addr=5 after REQ-041 -> ram_ld high for one cycle; if_rdata=20'hABCDE when if_ready pulses.
REQ-043 Round-robin, FAIR=1: both ports request continuously from reset -> grants alternate DM, IF, DM, IF; ready pulses every 3 cycles, never simultaneous.
REQ-044 Fixed priority, FAIR=0: both ports request continuously -> every grant goes to the data port; if_ready stays 0 until dm_req drops.
REQ-045 Reset mid-access: rst_n=0 during SERVE of a write to address 3 -> ram_str falls immediately, no dm_ready, all outputs 0.
REQ-046 Boundary: read at address 10'h3FF after writing 20'hFFFFF there -> dm_rdata=20'hFFFFF, and dm_rdata is unchanged by a subsequent write.
